itf_dram_xfer: RTL and testbench
================================

// Module: itf_dram_xfer
// PURPOSE
// Chip-side off-chip transfer controller, directly downstream of the shared pad bus driven by the host/DRAM model.
// Arbitrates on-chip DRAM requests onto the 128-bit pad bus: emits a command beat, then streams read data in or write data out.
// Also accepts unsolicited ISA bursts from the host and forwards them to the config path.
// PARAMETERS
// PORT_WIDTH       128  pad data width (bits per beat)
// DRAM_ADDR_WIDTH  32   DRAM word address width in the command beat
// ADDR_WIDTH       16   request length field width (units of 2*PORT_WIDTH)
// PORTS
// clk          in   1            core clock
// rst_n        in   1            asynchronous active-low reset
// I_ReqVld     in   1            on-chip DRAM request valid
// I_ReqWr      in   1            1: chip->DRAM write, 0: DRAM->chip read
// I_ReqAddr    in   32           DRAM start address (PORT_WIDTH words)
// I_ReqNum     in   16           length in 2*PORT_WIDTH words
// O_ReqRdy     out  1            request accepted when Vld&Rdy
// I_WrDat      in   PORT_WIDTH   write data from chip
// I_WrDatVld   in   1            write data valid
// O_WrDatRdy   out  1            write data consumed
// O_RdDat      out  PORT_WIDTH   read data to chip
// O_RdDatVld   out  1            read data valid
// I_RdDatRdy   in   1            chip sink ready
// O_IsaDat     out  PORT_WIDTH   ISA beat to config path
// O_IsaVld     out  1            ISA beat valid
// I_IsaRdy     in   1            config path ready
// O_Dat        out  PORT_WIDTH   pad output data (command or write beat)
// I_Dat        in   PORT_WIDTH   pad input data
// O_DatOE      out  1            1: chip drives pad bus
// O_CmdVld     out  1            current output beat is a command
// O_DatVld     out  1            output beat valid
// O_DatLast    out  1            last output write beat
// I_DatRdy     in   1            host accepts output beat
// I_DatVld     in   1            host input beat valid
// I_DatLast    in   1            last input beat of burst
// I_ISAVld     in   1            input burst is ISA
// O_DatRdy     out  1            chip accepts input beat
// O_ErrLen     out  1            sticky: read burst length mismatch
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; beat counter, latched request, O_ErrLen cleared.
// - FSM states IDLE, ISA, CMD, IN, OUT; registered state, outputs combinational from state + handshakes.
// - IDLE: I_DatVld&I_ISAVld has priority: beat passes through (O_IsaVld=1, O_DatRdy=I_IsaRdy); if accepted and !I_DatLast -> ISA.
// - IDLE, no input beat: O_ReqRdy=1; on I_ReqVld latch Wr/Addr/Num, total=Num*2 (17-bit); Num==0 -> stay IDLE, nothing issued; else -> CMD.
// - ISA: forwards beats as in IDLE; O_ReqRdy=0; on accepted beat with I_DatLast -> IDLE.
// - CMD: O_DatOE=O_DatVld=O_CmdVld=1; O_Dat={0.., Num[16], Addr[32], Wr}: bit0=Wr, [1+:32]=Addr, [33+:16]=Num. Held stable until I_DatRdy -> OUT if Wr else IN; counter cleared.
// - OUT: O_DatOE=1, O_DatVld=I_WrDatVld, O_Dat=I_WrDat, O_WrDatRdy=I_DatRdy; O_DatLast=(cnt==total-1); cnt++ per handshake; last handshake -> IDLE.
// - IN: O_DatOE=0; O_RdDat=I_Dat; O_RdDatVld=I_DatVld&!I_ISAVld; O_DatRdy=I_RdDatRdy; cnt++ per handshake.
// - IN exit: handshake where I_DatLast or cnt==total-1 -> IDLE; if the two disagree set O_ErrLen (sticky until reset).
// - O_DatOE=0 in IDLE/ISA/IN; O_Dat=0 when !O_DatOE; no pad conflict across state changes (OE drops same cycle as exit).
// - ISA beats arriving in CMD/OUT/IN are not accepted (O_DatRdy=0 unless state IN and !I_ISAVld).
// - Counter width 17 bits; Num=16'hFFFF -> total 131070 beats, no wrap.
// - Async reset mid-transfer: returns to IDLE immediately, request dropped; requester must reissue.
// TESTING
// - Read: Req{Wr=0,Addr=0x100,Num=2} -> cmd beat O_Dat=0x0..(2<<33)|(0x100<<1); then 4 input beats forwarded, DatLast on 4th -> IDLE, ErrLen=0.
// - Write: Req{Wr=1,Addr=0x40,Num=1}, I_DatRdy toggling -> cmd bit0=1, 2 write beats, O_DatLast only on 2nd handshake.
// - ISA burst of 16 beats while I_ReqVld=1 -> all 16 on O_IsaDat, O_ReqRdy=0 until burst last, then request proceeds.
// - Read Num=2 with host I_DatLast on beat 3 -> exit after beat 3, O_ErrLen=1 sticky; Num=0 -> accepted, no command.
// - Backpressure: I_RdDatRdy=0 for 5 cycles mid-read -> O_DatRdy=0, no beat lost or duplicated, counter holds.
// - rst_n low during OUT beat 3 of 8 -> all outputs 0 next edge-free instant, state IDLE, new request served cleanly.

Source files
------------

// File: rtl/itf_dram_xfer_if.sv
// Pad-bus and on-chip request/data bundle for itf_dram_xfer.
// master = the transfer controller, slave = host/DRAM model plus on-chip clients.
interface itf_dram_xfer_if #(
   parameter int PORT_WIDTH      = 128,
   parameter int DRAM_ADDR_WIDTH = 32,
   parameter int ADDR_WIDTH      = 16
);
   logic                       I_ReqVld;
   logic                       I_ReqWr;
   logic [DRAM_ADDR_WIDTH-1:0] I_ReqAddr;
   logic [ADDR_WIDTH-1:0]      I_ReqNum;
   logic                       O_ReqRdy;
   logic [PORT_WIDTH-1:0]      I_WrDat;
   logic                       I_WrDatVld;
   logic                       O_WrDatRdy;
   logic [PORT_WIDTH-1:0]      O_RdDat;
   logic                       O_RdDatVld;
   logic                       I_RdDatRdy;
   logic [PORT_WIDTH-1:0]      O_IsaDat;
   logic                       O_IsaVld;
   logic                       I_IsaRdy;
   logic [PORT_WIDTH-1:0]      O_Dat;
   logic [PORT_WIDTH-1:0]      I_Dat;
   logic                       O_DatOE;
   logic                       O_CmdVld;
   logic                       O_DatVld;
   logic                       O_DatLast;
   logic                       I_DatRdy;
   logic                       I_DatVld;
   logic                       I_DatLast;
   logic                       I_ISAVld;
   logic                       O_DatRdy;
   logic                       O_ErrLen;

   modport master (
      input  I_ReqVld, I_ReqWr, I_ReqAddr, I_ReqNum, I_WrDat, I_WrDatVld, I_RdDatRdy,
             I_IsaRdy, I_Dat, I_DatRdy, I_DatVld, I_DatLast, I_ISAVld,
      output O_ReqRdy, O_WrDatRdy, O_RdDat, O_RdDatVld, O_IsaDat, O_IsaVld, O_Dat,
             O_DatOE, O_CmdVld, O_DatVld, O_DatLast, O_DatRdy, O_ErrLen
   );

   modport slave (
      output I_ReqVld, I_ReqWr, I_ReqAddr, I_ReqNum, I_WrDat, I_WrDatVld, I_RdDatRdy,
             I_IsaRdy, I_Dat, I_DatRdy, I_DatVld, I_DatLast, I_ISAVld,
      input  O_ReqRdy, O_WrDatRdy, O_RdDat, O_RdDatVld, O_IsaDat, O_IsaVld, O_Dat,
             O_DatOE, O_CmdVld, O_DatVld, O_DatLast, O_DatRdy, O_ErrLen
   );
endinterface

// File: rtl/itf_dram_xfer.sv
// Off-chip transfer controller: issues a command beat on the pad bus, then streams
// read data in or write data out; unsolicited ISA bursts are forwarded to the config path.
module itf_dram_xfer #(
   parameter int PORT_WIDTH      = 128,
   parameter int DRAM_ADDR_WIDTH = 32,
   parameter int ADDR_WIDTH      = 16
) (
   input logic            clk,
   input logic            rst_n,
   itf_dram_xfer_if.master bus
);
   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {S_IDLE, S_ISA, S_CMD, S_IN, S_OUT} state_e;

   state_e                     state_q, state_d;
   logic                       live_q, live_d;
   logic                       wr_q, wr_d;
   logic [DRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]      num_q, num_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       err_q, err_d;

   logic [CNT_W-1:0]      last_idx;
   logic                  at_last;
   logic                  isa_beat;
   logic                  rd_beat;
   logic [PORT_WIDTH-1:0] cmd_beat;

   // Burst length counts single pad beats; the request length is in double beats.
   assign last_idx = {num_q, 1'b0} - CNT_W'(1);
   assign at_last  = (cnt_q == last_idx);
   assign isa_beat = bus.I_DatVld & bus.I_ISAVld;
   assign rd_beat  = bus.I_DatVld & ~bus.I_ISAVld;
   assign live_d   = 1'b1;

   always_comb begin
      cmd_beat                                = '0;
      cmd_beat[0]                             = wr_q;
      cmd_beat[1 +: DRAM_ADDR_WIDTH]          = addr_q;
      cmd_beat[1+DRAM_ADDR_WIDTH +: ADDR_WIDTH] = num_q;
   end

   always_comb begin
      // NOTE: every _d and every output is defaulted up front so no path through the case infers a latch.
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      bus.O_ReqRdy   = 1'b0;
      bus.O_WrDatRdy = 1'b0;
      bus.O_RdDat    = '0;
      bus.O_RdDatVld = 1'b0;
      bus.O_IsaDat   = '0;
      bus.O_IsaVld   = 1'b0;
      bus.O_Dat      = '0;
      bus.O_DatOE    = 1'b0;
      bus.O_CmdVld   = 1'b0;
      bus.O_DatVld   = 1'b0;
      bus.O_DatLast  = 1'b0;
      bus.O_DatRdy   = 1'b0;
      bus.O_ErrLen   = err_q;

      // live_q keeps every output quiet while reset is held and for the first edge after it.
      if (live_q) begin
         unique case (state_q)
            S_IDLE, S_ISA: begin
               bus.O_IsaDat = isa_beat ? bus.I_Dat : '0;
               bus.O_IsaVld = isa_beat;
               bus.O_DatRdy = bus.I_ISAVld & bus.I_IsaRdy;
               bus.O_ReqRdy = (state_q == S_IDLE) & ~isa_beat;
               if (isa_beat & bus.I_IsaRdy) begin
                  state_d = bus.I_DatLast ? S_IDLE : S_ISA;
               end else if (bus.O_ReqRdy & bus.I_ReqVld) begin
                  wr_d    = bus.I_ReqWr;
                  addr_d  = bus.I_ReqAddr;
                  num_d   = bus.I_ReqNum;
                  state_d = (bus.I_ReqNum == '0) ? S_IDLE : S_CMD;
               end
            end
            S_CMD: begin
               bus.O_DatOE  = 1'b1;
               bus.O_DatVld = 1'b1;
               bus.O_CmdVld = 1'b1;
               bus.O_Dat    = cmd_beat;
               if (bus.I_DatRdy) begin
                  state_d = wr_q ? S_OUT : S_IN;
                  cnt_d   = '0;
               end
            end
            S_OUT: begin
               bus.O_DatOE    = 1'b1;
               bus.O_DatVld   = bus.I_WrDatVld;
               bus.O_Dat      = bus.I_WrDat;
               bus.O_WrDatRdy = bus.I_DatRdy;
               bus.O_DatLast  = bus.I_WrDatVld & at_last;
               if (bus.I_WrDatVld & bus.I_DatRdy) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (at_last) state_d = S_IDLE;
               end
            end
            S_IN: begin
               bus.O_RdDat    = bus.I_Dat;
               bus.O_RdDatVld = rd_beat;
               bus.O_DatRdy   = ~bus.I_ISAVld & bus.I_RdDatRdy;
               if (rd_beat & bus.I_RdDatRdy) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  // Host and requester disagreeing on burst length is flagged, not fatal.
                  if (bus.I_DatLast | at_last) begin
                     state_d = S_IDLE;
                     if (bus.I_DatLast != at_last) err_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         live_q  <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_itf_dram_xfer.sv
// Scoreboard bench for itf_dram_xfer: beats are queued when driven and compared when the
// DUT hands them over; inputs change #1 after posedge, outputs are sampled on negedge.
module tb_itf_dram_xfer;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [127:0] sb[$];

   always #5 clk = ~clk;

   itf_dram_xfer_if bus ();

   itf_dram_xfer dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   wire any_out = |{bus.O_ReqRdy, bus.O_WrDatRdy, bus.O_RdDat, bus.O_RdDatVld, bus.O_IsaDat,
                    bus.O_IsaVld, bus.O_Dat, bus.O_DatOE, bus.O_CmdVld, bus.O_DatVld,
                    bus.O_DatLast, bus.O_DatRdy, bus.O_ErrLen};

   function automatic logic [127:0] rnd();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Request handshake followed by the command beat, held for 'hold' cycles of I_DatRdy=0.
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] num,
                           input int hold);
      logic [127:0] exp_cmd;
      exp_cmd        = '0;
      exp_cmd[0]     = wr;
      exp_cmd[32:1]  = addr;
      exp_cmd[48:33] = num;
      bus.I_ReqVld  = 1'b1;
      bus.I_ReqWr   = wr;
      bus.I_ReqAddr = addr;
      bus.I_ReqNum  = num;
      bus.I_DatRdy  = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.O_ReqRdy !== 1'b1) begin
         failures++;
         $display("FAIL req_rdy: got %b exp 1", bus.O_ReqRdy);
      end
      @(posedge clk); #1;
      bus.I_ReqVld = 1'b0;
      if (num == 16'd0) begin
         @(negedge clk);
         checks++;
         if ({bus.O_CmdVld, bus.O_DatOE, bus.O_ReqRdy} !== 3'b001) begin
            failures++;
            $display("FAIL num_zero: got cmd/oe/rdy=%b exp 001",
                     {bus.O_CmdVld, bus.O_DatOE, bus.O_ReqRdy});
         end
         @(posedge clk); #1;
         return;
      end
      for (int i = 0; i <= hold; i++) begin
         bus.I_DatRdy = (i == hold);
         @(negedge clk);
         checks++;
         if (bus.O_CmdVld !== 1'b1 || bus.O_DatOE !== 1'b1 || bus.O_DatVld !== 1'b1 ||
             bus.O_Dat !== exp_cmd) begin
            failures++;
            $display("FAIL cmd_beat: got vld=%b oe=%b dat=%h exp dat=%h",
                     bus.O_CmdVld, bus.O_DatOE, bus.O_Dat, exp_cmd);
         end
         @(posedge clk); #1;
      end
      bus.I_DatRdy = 1'b0;
   endtask

   // Host streams nbeats read beats (I_DatLast on beat last_at); sink stalls on the given window.
   task automatic run_read(input int nbeats, input int last_at, input int stall_at,
                           input int stall_len, input logic exp_err);
      int sent = 0, got = 0, cyc = 0;
      logic pend = 1'b0;
      logic stall;
      logic [127:0] d, e;
      sb.delete();
      while (got < nbeats && cyc < 200) begin
         if (!pend && sent < nbeats) begin
            d = rnd();
            bus.I_Dat     = d;
            bus.I_DatVld  = 1'b1;
            bus.I_ISAVld  = 1'b0;
            bus.I_DatLast = (sent + 1 == last_at);
            sb.push_back(d);
            sent++;
            pend = 1'b1;
         end
         stall = (cyc >= stall_at) && (cyc < stall_at + stall_len);
         bus.I_RdDatRdy = ~stall;
         @(negedge clk);
         if (stall) begin
            checks++;
            if (bus.O_DatRdy !== 1'b0) begin
               failures++;
               $display("FAIL rd_stall: O_DatRdy got %b exp 0", bus.O_DatRdy);
            end
         end
         if (bus.O_RdDatVld === 1'b1 && bus.O_DatRdy === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (bus.O_RdDat !== e || bus.O_DatOE !== 1'b0) begin
               failures++;
               $display("FAIL rd_beat %0d: got %h oe=%b exp %h", got, bus.O_RdDat, bus.O_DatOE, e);
            end
            got++;
            pend = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (got < nbeats) begin
         failures++;
         $display("FAIL rd_timeout: got %0d beats exp %0d", got, nbeats);
      end
      bus.I_DatVld   = 1'b0;
      bus.I_DatLast  = 1'b0;
      bus.I_RdDatRdy = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.O_ReqRdy !== 1'b1 || bus.O_DatOE !== 1'b0) begin
         failures++;
         $display("FAIL rd_idle: got rdy=%b oe=%b exp rdy=1 oe=0", bus.O_ReqRdy, bus.O_DatOE);
      end
      checks++;
      if (bus.O_ErrLen !== exp_err) begin
         failures++;
         $display("FAIL err_len: got %b exp %b", bus.O_ErrLen, exp_err);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL rd_left: got %0d unconsumed beats exp 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   // Chip supplies write beats; stops after stop_after handshakes of an nbeats burst.
   task automatic run_write(input int nbeats, input int stop_after, input logic toggle);
      int got = 0, cyc = 0;
      logic pend = 1'b0;
      logic [127:0] d, e;
      sb.delete();
      while (got < stop_after && cyc < 200) begin
         if (!pend) begin
            d = rnd();
            bus.I_WrDat    = d;
            bus.I_WrDatVld = 1'b1;
            sb.push_back(d);
            pend = 1'b1;
         end
         bus.I_DatRdy = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         if (bus.O_DatVld === 1'b1 && bus.I_DatRdy) begin
            e = sb.pop_front();
            checks++;
            if (bus.O_Dat !== e || bus.O_WrDatRdy !== 1'b1 || bus.O_CmdVld !== 1'b0 ||
                bus.O_DatOE !== 1'b1) begin
               failures++;
               $display("FAIL wr_beat %0d: got %h rdy=%b cmd=%b oe=%b exp %h", got, bus.O_Dat,
                        bus.O_WrDatRdy, bus.O_CmdVld, bus.O_DatOE, e);
            end
            checks++;
            if (bus.O_DatLast !== (got == nbeats - 1)) begin
               failures++;
               $display("FAIL wr_last %0d: got %b exp %b", got, bus.O_DatLast, got == nbeats - 1);
            end
            got++;
            pend = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (got < stop_after) begin
         failures++;
         $display("FAIL wr_timeout: got %0d beats exp %0d", got, stop_after);
      end
      bus.I_WrDatVld = 1'b0;
      bus.I_DatRdy   = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.I_ReqVld = 1'b0; bus.I_ReqWr = 1'b0; bus.I_ReqAddr = '0; bus.I_ReqNum = '0;
      bus.I_WrDat = '0; bus.I_WrDatVld = 1'b0; bus.I_RdDatRdy = 1'b0; bus.I_IsaRdy = 1'b0;
      bus.I_Dat = '0; bus.I_DatRdy = 1'b0; bus.I_DatVld = 1'b0; bus.I_DatLast = 1'b0;
      bus.I_ISAVld = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (any_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs: got nonzero outputs exp all 0");
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.O_ReqRdy !== 1'b1 || bus.O_DatOE !== 1'b0 || bus.O_ErrLen !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got rdy=%b oe=%b err=%b exp 1 0 0",
                  bus.O_ReqRdy, bus.O_DatOE, bus.O_ErrLen);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_read();
      send_cmd(1'b0, 32'h100, 16'd2, 0);
      run_read(4, 4, 0, 0, 1'b0);
   endtask

   task automatic test_write();
      send_cmd(1'b1, 32'h40, 16'd1, 2);
      run_write(2, 2, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.O_ReqRdy !== 1'b1 || bus.O_DatOE !== 1'b0) begin
         failures++;
         $display("FAIL wr_idle: got rdy=%b oe=%b exp rdy=1 oe=0", bus.O_ReqRdy, bus.O_DatOE);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_isa();
      int sent = 0, got = 0, cyc = 0;
      logic pend = 1'b0;
      logic [127:0] d, e;
      sb.delete();
      bus.I_ReqVld  = 1'b1;
      bus.I_ReqWr   = 1'b0;
      bus.I_ReqAddr = 32'h200;
      bus.I_ReqNum  = 16'd1;
      while (got < 16 && cyc < 400) begin
         if (!pend) begin
            d = rnd();
            bus.I_Dat     = d;
            bus.I_DatVld  = 1'b1;
            bus.I_ISAVld  = 1'b1;
            bus.I_DatLast = (sent == 15);
            sb.push_back(d);
            sent++;
            pend = 1'b1;
         end
         bus.I_IsaRdy = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++;
         if (bus.O_ReqRdy !== 1'b0 || bus.O_DatOE !== 1'b0) begin
            failures++;
            $display("FAIL isa_hold_req: got rdy=%b oe=%b exp 0 0", bus.O_ReqRdy, bus.O_DatOE);
         end
         if (bus.O_IsaVld === 1'b1 && bus.O_DatRdy === 1'b1) begin
            e = sb.pop_front();
            checks++;
            if (bus.O_IsaDat !== e) begin
               failures++;
               $display("FAIL isa_beat %0d: got %h exp %h", got, bus.O_IsaDat, e);
            end
            got++;
            pend = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (got < 16) begin
         failures++;
         $display("FAIL isa_timeout: got %0d beats exp 16", got);
      end
      bus.I_DatVld  = 1'b0;
      bus.I_ISAVld  = 1'b0;
      bus.I_DatLast = 1'b0;
      bus.I_IsaRdy  = 1'b0;
      send_cmd(1'b0, 32'h200, 16'd1, 0);
      run_read(2, 2, 0, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      send_cmd(1'b0, 32'h1234, 16'd2, 0);
      run_read(4, 4, 2, 5, 1'b0);
   endtask

   task automatic test_len_err();
      send_cmd(1'b0, 32'h500, 16'd2, 0);
      run_read(3, 3, 0, 0, 1'b1);
   endtask

   task automatic test_num_zero();
      send_cmd(1'b0, 32'h300, 16'd0, 0);
      @(negedge clk);
      checks++;
      if (bus.O_ErrLen !== 1'b1 || bus.O_CmdVld !== 1'b0) begin
         failures++;
         $display("FAIL err_sticky: got err=%b cmd=%b exp err=1 cmd=0", bus.O_ErrLen, bus.O_CmdVld);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b1, 32'h80, 16'd4, 0);
      run_write(8, 2, 1'b0);
      bus.I_WrDat    = rnd();
      bus.I_WrDatVld = 1'b1;
      bus.I_DatRdy   = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (any_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: got nonzero outputs exp all 0");
      end
      @(negedge clk);
      checks++;
      if (any_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_hold: got nonzero outputs exp all 0");
      end
      @(posedge clk); #1;
      rst_n          = 1'b1;
      bus.I_WrDatVld = 1'b0;
      bus.I_DatRdy   = 1'b0;
      @(posedge clk); #1;
      send_cmd(1'b0, 32'h10, 16'd1, 0);
      run_read(2, 2, 0, 0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_isa();
      test_backpressure();
      test_len_err();
      test_num_zero();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
